// File: rtl/ps2_game_key_decoder.sv
// rtl/ps2_game_key_decoder.sv - PS/2 scan-code stream to game controls (left/right/fire/pause).
module ps2_game_key_decoder #(
  parameter logic [7:0]  KEY_LEFT      = 8'h6B,
  parameter logic [7:0]  KEY_RIGHT     = 8'h74,
  parameter logic [7:0]  KEY_FIRE      = 8'h29,
  parameter logic [7:0]  KEY_PAUSE     = 8'h4D,
  parameter logic [23:0] FIRE_COOLDOWN = 24'd5000000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] ps2_key_data,
  input  logic       ps2_key_pressed,
  output logic       move_left,
  output logic       move_right,
  output logic       fire,
  output logic       pause,
  output logic [7:0] ps2_out
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXT,
    S_BRK,
    S_EXT_BRK,
    S_SKIP
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  skip_cnt_q, skip_cnt_d;
  logic        held_l_q, held_l_d;
  logic        held_r_q, held_r_d;
  logic        held_f_q, held_f_d;
  logic        held_p_q, held_p_d;
  logic        last_left_q, last_left_d;
  logic        pause_q, pause_d;
  logic        fire_q, fire_d;
  logic [7:0]  out_q, out_d;
  logic        do_make, do_break;
  logic        fire_ok;

`ifdef FIRE_RATE_LIMIT_EN
  logic [23:0] cooldown_q, cooldown_d;
  assign fire_ok = (cooldown_q == 24'd0);
`else
  assign fire_ok = 1'b1;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      skip_cnt_q  <= 3'd0;
      held_l_q    <= 1'b0;
      held_r_q    <= 1'b0;
      held_f_q    <= 1'b0;
      held_p_q    <= 1'b0;
      last_left_q <= 1'b0;
      pause_q     <= 1'b0;
      fire_q      <= 1'b0;
      out_q       <= 8'h00;
`ifdef FIRE_RATE_LIMIT_EN
      cooldown_q  <= 24'd0;
`endif
    end else begin
      state_q     <= state_d;
      skip_cnt_q  <= skip_cnt_d;
      held_l_q    <= held_l_d;
      held_r_q    <= held_r_d;
      held_f_q    <= held_f_d;
      held_p_q    <= held_p_d;
      last_left_q <= last_left_d;
      pause_q     <= pause_d;
      fire_q      <= fire_d;
      out_q       <= out_d;
`ifdef FIRE_RATE_LIMIT_EN
      cooldown_q  <= cooldown_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    skip_cnt_d  = skip_cnt_q;
    held_l_d    = held_l_q;
    held_r_d    = held_r_q;
    held_f_d    = held_f_q;
    held_p_d    = held_p_q;
    last_left_d = last_left_q;
    pause_d     = pause_q;
    fire_d      = 1'b0;
    out_d       = out_q;
    do_make     = 1'b0;
    do_break    = 1'b0;

    if (ps2_key_pressed) begin
      case (state_q)
        S_IDLE: begin
          if (ps2_key_data == 8'hE0) begin
            state_d = S_EXT;
          end else if (ps2_key_data == 8'hF0) begin
            state_d = S_BRK;
          end else if (ps2_key_data == 8'hE1) begin
            state_d    = S_SKIP;
            skip_cnt_d = 3'd7;
          end else if (!(ps2_key_data inside {8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'h00, 8'hFF})) begin
            do_make = 1'b1;
          end
        end
        S_EXT: begin
          if (ps2_key_data == 8'hF0) begin
            state_d = S_EXT_BRK;
          end else if (ps2_key_data != 8'hE0) begin
            do_make = 1'b1;
            state_d = S_IDLE;
          end
        end
        S_BRK, S_EXT_BRK: begin
          do_break = 1'b1;
          state_d  = S_IDLE;
        end
        S_SKIP: begin
          skip_cnt_d = skip_cnt_q - 3'd1;
          if (skip_cnt_q == 3'd1) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end

    if (do_make) begin
      out_d = ps2_key_data;
      if (ps2_key_data == KEY_LEFT) begin
        held_l_d    = 1'b1;
        last_left_d = 1'b1;
      end
      if (ps2_key_data == KEY_RIGHT) begin
        held_r_d    = 1'b1;
        last_left_d = 1'b0;
      end
      if (ps2_key_data == KEY_FIRE && !held_f_q) begin
        held_f_d = 1'b1;
        fire_d   = fire_ok;
      end
      if (ps2_key_data == KEY_PAUSE && !held_p_q) begin
        held_p_d = 1'b1;
        pause_d  = ~pause_q;
      end
    end

    if (do_break) begin
      if (ps2_key_data == KEY_LEFT)  held_l_d = 1'b0;
      if (ps2_key_data == KEY_RIGHT) held_r_d = 1'b0;
      if (ps2_key_data == KEY_FIRE)  held_f_d = 1'b0;
      if (ps2_key_data == KEY_PAUSE) held_p_d = 1'b0;
    end
  end

`ifdef FIRE_RATE_LIMIT_EN
  always_comb begin
    cooldown_d = cooldown_q;
    if (fire_d)                   cooldown_d = FIRE_COOLDOWN;
    else if (cooldown_q != 24'd0) cooldown_d = cooldown_q - 24'd1;
  end
`endif

  assign move_left  = held_l_q & (~held_r_q | last_left_q);
  assign move_right = held_r_q & (~held_l_q | ~last_left_q);
  assign fire       = fire_q;
  assign pause      = pause_q;
  assign ps2_out    = out_q;

endmodule
